// File: rtl/imm_extend_pipe_if.sv
// rtl/imm_extend_pipe_if.sv - instruction-in / immediate-out stream bundle for imm_extend_pipe
// master drives instruction words and out_ready; slave is the immediate stage.
interface imm_extend_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [2:0]      imm_src;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_type;
  logic            out_err;

  modport master (
    output in_valid, in_instr, imm_src, out_ready,
    input  in_ready, out_valid, out_imm, out_type, out_err
  );

  modport slave (
    input  in_valid, in_instr, imm_src, out_ready,
    output in_ready, out_valid, out_imm, out_type, out_err
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - registered RV32/RV64 immediate generator with 2-entry skid buffer
// Optional macro IMM_ERR_EN: registers an out_err flag that travels with each illegal word.
module imm_extend_pipe #(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  imm_extend_pipe_if.slave  bus
);

  localparam logic [2:0] T_I    = 3'b000;
  localparam logic [2:0] T_S    = 3'b001;
  localparam logic [2:0] T_B    = 3'b010;
  localparam logic [2:0] T_J    = 3'b011;
  localparam logic [2:0] T_U    = 3'b100;
  localparam logic [2:0] T_Z    = 3'b101;
  localparam logic [2:0] T_NONE = 3'b111;

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic            sgn;
  logic [2:0]      dec_type;
  logic [2:0]      cur_type;
  logic [XLEN-1:0] cur_imm;

  logic            out_valid_q;
  logic [XLEN-1:0] out_imm_q;
  logic [2:0]      out_type_q;
  logic            skid_valid_q;
  logic [XLEN-1:0] skid_imm_q;
  logic [2:0]      skid_type_q;

  logic            in_fire;
  logic            out_free;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign sgn    = instr[31];

  always_comb begin
    dec_type = T_NONE;
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111: dec_type = T_I;
      7'b0100011:                         dec_type = T_S;
      7'b1100011:                         dec_type = T_B;
      7'b1101111:                         dec_type = T_J;
      7'b0110111, 7'b0010111:             dec_type = T_U;
      7'b1110011:                         dec_type = instr[14] ? T_Z : T_I;
      default:                            dec_type = T_NONE;
    endcase
  end

  // Selector codes 110/111 collapse onto the illegal type.
  always_comb begin
    cur_type = T_NONE;
    if (AUTO_DECODE != 0) begin
      cur_type = dec_type;
    end else if (bus.imm_src <= T_Z) begin
      cur_type = bus.imm_src;
    end
  end

  always_comb begin
    cur_imm = '0;
    case (cur_type)
      T_I: cur_imm = {{(XLEN-12){sgn}}, instr[31:20]};
      T_S: cur_imm = {{(XLEN-12){sgn}}, instr[31:25], instr[11:7]};
      T_B: cur_imm = {{(XLEN-12){sgn}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      T_J: cur_imm = {{(XLEN-20){sgn}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      T_U: cur_imm = XLEN'($signed({instr[31:12], 12'b0}));
      T_Z: cur_imm = {{(XLEN-5){1'b0}}, instr[19:15]};
      default: cur_imm = '0;
    endcase
  end

  // in_ready comes straight from the skid flop, so out_ready never reaches it.
  assign in_fire  = bus.in_valid && !skid_valid_q;
  assign out_free = !out_valid_q || bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_type_q   <= T_NONE;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_type_q  <= T_NONE;
    end else if (skid_valid_q) begin
      if (bus.out_ready) begin
        out_imm_q    <= skid_imm_q;
        out_type_q   <= skid_type_q;
        skid_valid_q <= 1'b0;
      end
    end else if (in_fire) begin
      if (out_free) begin
        out_valid_q <= 1'b1;
        out_imm_q   <= cur_imm;
        out_type_q  <= cur_type;
      end else begin
        skid_valid_q <= 1'b1;
        skid_imm_q   <= cur_imm;
        skid_type_q  <= cur_type;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef IMM_ERR_EN
  logic cur_err;
  logic out_err_q;
  logic skid_err_q;

  assign cur_err = (cur_type == T_NONE);

  // Mirrors the payload moves above so the flag stays attached to its word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_err_q  <= 1'b0;
      skid_err_q <= 1'b0;
    end else if (skid_valid_q) begin
      if (bus.out_ready) begin
        out_err_q <= skid_err_q;
      end
    end else if (in_fire) begin
      if (out_free) begin
        out_err_q <= cur_err;
      end else begin
        skid_err_q <= cur_err;
      end
    end
  end

  assign bus.out_err = out_err_q;
`else
  assign bus.out_err = 1'b0;
`endif

  assign bus.in_ready  = !skid_valid_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_imm   = out_imm_q;
  assign bus.out_type  = out_type_q;

endmodule
